if_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register. Holds the PC and issues

---
 rtl/if_stage.sv | 138 +++++++++++++
 tb/tb_if_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, talks to a variable-latency instruction memory over req/ack,
// parks one word in a skid buffer under stall, and drains an abandoned
// request after a redirect so only one request is ever outstanding.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        misalign
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_next;
    logic        started;
    logic [31:0] pc, pc_next;
    logic [31:0] drain_addr;
    logic [31:0] skid_instr, skid_pc;

    logic        ifid_load_mem;
    logic        ifid_load_skid;
    logic        ifid_bubble;
    logic        skid_load;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    // Next-state, PC update and IF/ID action select; memory request outputs
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        ifid_load_mem  = 1'b0;
        ifid_load_skid = 1'b0;
        ifid_bubble    = 1'b0;
        skid_load      = 1'b0;
        imem_req       = 1'b0;
        imem_addr      = pc;
        unique case (state)
            FETCH: begin
                // started gates the request for the cycle right after reset
                imem_req = started;
                if (redirect) begin
                    ifid_bubble = 1'b1;
                    pc_next     = redirect_aligned;
                    if (started && !imem_ack) state_next = DRAIN;
                end else if (started && imem_ack) begin
                    pc_next = pc + 32'd4;
                    if (stall) begin
                        skid_load  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        ifid_load_mem = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_bubble = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    ifid_bubble = 1'b1;
                    pc_next     = redirect_aligned;
                    state_next  = FETCH;
                end else if (!stall) begin
                    ifid_load_skid = 1'b1;
                    state_next     = FETCH;
                end
            end
            DRAIN: begin
                // keep presenting the abandoned address until it is acked
                imem_req    = 1'b1;
                imem_addr   = drain_addr;
                ifid_bubble = 1'b1;
                if (redirect) pc_next = redirect_aligned;
                if (imem_ack) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // State, PC, skid buffer and IF/ID register updates
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            started    <= 1'b0;
            pc         <= RESET_PC;
            drain_addr <= '0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_pc4   <= 32'd4;
            ifid_instr <= NOP_INSTR;
            misalign   <= 1'b0;
        end else begin
            state    <= state_next;
            started  <= 1'b1;
            pc       <= pc_next;
            misalign <= redirect && (redirect_pc[1:0] != 2'b00);
            if (state == FETCH && state_next == DRAIN) drain_addr <= pc;
            if (skid_load) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end
            if (ifid_bubble) begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_INSTR;
            end else if (ifid_load_mem) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= pc;
                ifid_pc4   <= pc + 32'd4;
                ifid_instr <= imem_rdata;
            end else if (ifid_load_skid) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= skid_pc;
                ifid_pc4   <= skid_pc + 32'd4;
                ifid_instr <= skid_instr;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0093;
    localparam logic [31:0] I1  = 32'h00A0_0113;
    localparam logic [31:0] I2  = 32'h0020_81B3;
    localparam logic [31:0] JNK = 32'hDEAD_BEEF;

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
        .ifid_instr(ifid_instr), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // one clock edge, then settle before sampling and driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [31:0] data, input logic stl,
                         input logic rdr, input logic [31:0] rpc);
        imem_ack = ack; imem_rdata = data; stall = stl; redirect = rdr; redirect_pc = rpc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        step(); step();
        checks++; if (imem_req !== 1'b0)  begin errors++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", ifid_valid); end
        checks++; if (ifid_instr !== NOP)  begin errors++; $display("FAIL rst_instr got=%h exp=%h", ifid_instr, NOP); end
        checks++; if (ifid_pc !== 32'h0)   begin errors++; $display("FAIL rst_pc got=%h exp=0", ifid_pc); end
        checks++; if (ifid_pc4 !== 32'h4)  begin errors++; $display("FAIL rst_pc4 got=%h exp=4", ifid_pc4); end
        checks++; if (misalign !== 1'b0)   begin errors++; $display("FAIL rst_misalign got=%0b exp=0", misalign); end
        rst = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1)     begin errors++; $display("FAIL rel_req got=%0b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h0)   begin errors++; $display("FAIL rel_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] words [3];
        words[0] = I0; words[1] = I1; words[2] = I2;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, words[i], 1'b0, 1'b0, '0);
            step();
            checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%0b exp=1", i, ifid_valid); end
            checks++; if (ifid_pc !== 32'(4*i)) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, ifid_pc, 32'(4*i)); end
            checks++; if (ifid_pc4 !== 32'(4*i+4)) begin errors++; $display("FAIL stream_pc4[%0d] got=%h exp=%h", i, ifid_pc4, 32'(4*i+4)); end
            checks++; if (ifid_instr !== words[i]) begin errors++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, ifid_instr, words[i]); end
        end
    endtask

    task automatic test_stall();
        test_reset();
        drive(1'b1, I0, 1'b0, 1'b0, '0); step();
        drive(1'b1, I1, 1'b0, 1'b0, '0); step();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_pre_addr got=%h exp=8", imem_addr); end
        drive(1'b1, I2, 1'b1, 1'b0, '0); step();
        checks++; if (ifid_pc !== 32'h4)   begin errors++; $display("FAIL stall_hold_pc got=%h exp=4", ifid_pc); end
        checks++; if (ifid_instr !== I1)   begin errors++; $display("FAIL stall_hold_instr got=%h exp=%h", ifid_instr, I1); end
        checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL stall_req got=%0b exp=0", imem_req); end
        drive(1'b0, JNK, 1'b1, 1'b0, '0); step();
        checks++; if (ifid_pc !== 32'h4)   begin errors++; $display("FAIL stall_hold2_pc got=%h exp=4", ifid_pc); end
        checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL stall_req2 got=%0b exp=0", imem_req); end
        drive(1'b0, JNK, 1'b0, 1'b0, '0); step();
        checks++; if (ifid_pc !== 32'h8 || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_rel_pc got=%h/%0b exp=8/1", ifid_pc, ifid_valid); end
        checks++; if (ifid_instr !== I2)   begin errors++; $display("FAIL stall_rel_instr got=%h exp=%h", ifid_instr, I2); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_next_req got=%0b/%h exp=1/c", imem_req, imem_addr); end
    endtask

    task automatic test_drain();
        drive(1'b1, I0, 1'b0, 1'b0, '0); step();
        checks++; if (ifid_pc !== 32'hC || imem_addr !== 32'h10) begin errors++; $display("FAIL drain_setup got=%h/%h exp=c/10", ifid_pc, imem_addr); end
        drive(1'b0, JNK, 1'b0, 1'b1, 32'h100); step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL drain_w1 got=%0b/%h exp=1/10", imem_req, imem_addr); end
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin errors++; $display("FAIL drain_bubble got=%0b/%h exp=0/%h", ifid_valid, ifid_instr, NOP); end
        drive(1'b0, JNK, 1'b0, 1'b0, '0); step();
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL drain_w2 got=%h exp=10", imem_addr); end
        drive(1'b1, JNK, 1'b0, 1'b0, '0); step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL drain_next got=%0b/%h exp=1/100", imem_req, imem_addr); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL drain_discard got=%0b exp=0", ifid_valid); end
    endtask

    task automatic test_redirect_stall();
        drive(1'b1, I0, 1'b0, 1'b0, '0); step();
        checks++; if (ifid_pc !== 32'h100 || ifid_instr !== I0) begin errors++; $display("FAIL rs_setup got=%h/%h exp=100/%h", ifid_pc, ifid_instr, I0); end
        drive(1'b0, JNK, 1'b1, 1'b1, 32'h200); step();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rs_valid got=%0b exp=0", ifid_valid); end
        checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL rs_drain_addr got=%h exp=104", imem_addr); end
        drive(1'b1, JNK, 1'b0, 1'b0, '0); step();
        checks++; if (imem_addr !== 32'h200 || ifid_valid !== 1'b0) begin errors++; $display("FAIL rs_resume got=%h/%0b exp=200/0", imem_addr, ifid_valid); end
        drive(1'b1, I1, 1'b0, 1'b0, '0); step();
        checks++; if (ifid_pc !== 32'h200 || ifid_instr !== I1 || ifid_valid !== 1'b1) begin errors++; $display("FAIL rs_first got=%h/%h/%0b exp=200/%h/1", ifid_pc, ifid_instr, ifid_valid, I1); end
    endtask

    task automatic test_misalign_wrap();
        drive(1'b1, JNK, 1'b0, 1'b1, 32'h102); step();
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse got=%0b exp=1", misalign); end
        checks++; if (imem_addr !== 32'h100 || ifid_valid !== 1'b0) begin errors++; $display("FAIL mis_addr got=%h/%0b exp=100/0", imem_addr, ifid_valid); end
        drive(1'b1, JNK, 1'b0, 1'b1, 32'hFFFF_FFFC); step();
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got=%0b exp=0", misalign); end
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got=%h exp=fffffffc", imem_addr); end
        drive(1'b1, I2, 1'b0, 1'b0, '0); step();
        checks++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_ifid got=%h/%h exp=fffffffc/0", ifid_pc, ifid_pc4); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_drain();
        test_redirect_stall();
        test_misalign_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
